// File: rtl/uart_tx_arb_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   arb_state_e     : arbiter FSM states
//   BYTE_W          : width of one byte lane
//   NUM_REQ_DEFAULT : default requester count
//   ptr_w()         : width of a requester index / round-robin pointer
package uart_tx_arb_pkg;

  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned NUM_REQ_DEFAULT = 2;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StWaitBusy,
    StWaitDone
  } arb_state_e;

  // A one-bit index is kept even for a single requester so vectors never collapse to zero width.
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: selects the first asserted request at or after ptr_i,
// wrapping modulo N.
//   req_i : request vector
//   ptr_i : highest-priority index, must be < N
//   gnt_o : one-hot winner (zero when no request)
//   idx_o : index of the winner
//   any_o : at least one request present
module rr_picker
  import uart_tx_arb_pkg::*;
#(
  parameter int unsigned N    = NUM_REQ_DEFAULT,
  parameter int unsigned PtrW = ptr_w(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [PtrW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [PtrW-1:0] idx_o,
  output logic            any_o
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [PtrW:0]  sum;

  // Rotate so that bit 0 of rot is the requester at ptr_i.
  assign dbl = {req_i, req_i};
  assign rot = dbl[ptr_i +: N];

  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    sum   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!any_o && rot[k]) begin
        any_o = 1'b1;
        sum   = {1'b0, ptr_i} + (PtrW+1)'(k);
        if (sum >= (PtrW+1)'(N)) begin
          sum = sum - (PtrW+1)'(N);
        end
        idx_o = sum[PtrW-1:0];
      end
    end
    gnt_o = any_o ? (N'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte-stream requesters. A requester keeps the
// lock from its first byte through the byte flagged last, so packets never interleave.
// Optional feature macro: UART_TX_ARB_TIMEOUT_EN releases an idle lock after TIMEOUT_CYCLES.
//   clk, rst   : clock, asynchronous active-high reset
//   req_valid  : per-requester byte valid
//   req_data   : byte lanes, requester i on [8i+7:8i]
//   req_last   : per-requester end-of-packet flag
//   req_ready  : byte accepted this cycle (combinational)
//   grant      : one-hot lock owner (registered)
//   tx_data    : byte to the transmitter
//   tx_stb     : one-cycle send strobe to the transmitter
//   tx_busy    : transmitter busy
//   active     : a packet lock is held
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = NUM_REQ_DEFAULT,
  parameter int unsigned GUARD_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        grant,
  output logic [BYTE_W-1:0]         tx_data,
  output logic                      tx_stb,
  input  logic                      tx_busy,
  output logic                      active
);

  localparam int unsigned PtrW = ptr_w(NUM_REQ);
  localparam int unsigned GW   = $clog2(GUARD_CYCLES + 1);

  arb_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [PtrW-1:0]     gidx_q, gidx_d;
  logic [PtrW-1:0]     ptr_q, ptr_d;
  logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_stb_q, tx_stb_d;
  logic                last_q, last_d;
  logic                active_q, active_d;
  logic [GW-1:0]       guard_q, guard_d;
`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]       tout_q, tout_d;
`endif

  logic [NUM_REQ-1:0]  pick_gnt;
  logic [PtrW-1:0]     pick_idx;
  logic                pick_any;
  logic                accept;

  rr_picker #(
    .N    (NUM_REQ),
    .PtrW (PtrW)
  ) u_rr_picker (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      gidx_q    <= '0;
      ptr_q     <= '0;
      tx_data_q <= '0;
      tx_stb_q  <= 1'b0;
      last_q    <= 1'b0;
      active_q  <= 1'b0;
      guard_q   <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      tout_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      gidx_q    <= gidx_d;
      ptr_q     <= ptr_d;
      tx_data_q <= tx_data_d;
      tx_stb_q  <= tx_stb_d;
      last_q    <= last_d;
      active_q  <= active_d;
      guard_q   <= guard_d;
`ifdef UART_TX_ARB_TIMEOUT_EN
      tout_q    <= tout_d;
`endif
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    ptr_d     = ptr_q;
    tx_data_d = tx_data_q;
    tx_stb_d  = 1'b0;
    last_d    = last_q;
    active_d  = active_q;
    guard_d   = guard_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
    tout_d    = tout_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          grant_d  = pick_gnt;
          gidx_d   = pick_idx;
          active_d = 1'b1;
          state_d  = StSend;
        end
      end
      StSend: begin
        if (accept) begin
          tx_data_d = req_data[gidx_q*BYTE_W +: BYTE_W];
          last_d    = req_last[gidx_q];
          tx_stb_d  = 1'b1;
          state_d   = StWaitBusy;
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        else if (!req_valid[gidx_q]) begin
          if (tout_q == TW'(TIMEOUT_CYCLES - 1)) begin
            ptr_d    = (gidx_q == PtrW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
            grant_d  = '0;
            active_d = 1'b0;
            state_d  = StIdle;
          end else begin
            tout_d = tout_q + 1'b1;
          end
        end
`endif
      end
      StWaitBusy: begin
        // The guard covers a transmitter that never raises busy.
        if (tx_busy || (guard_q == GW'(GUARD_CYCLES - 1))) begin
          guard_d = '0;
          state_d = StWaitDone;
        end else begin
          guard_d = guard_q + 1'b1;
        end
      end
      StWaitDone: begin
        if (!tx_busy) begin
          if (last_q) begin
            ptr_d    = (gidx_q == PtrW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
            grant_d  = '0;
            active_d = 1'b0;
            state_d  = StIdle;
          end else begin
            state_d = StSend;
          end
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef UART_TX_ARB_TIMEOUT_EN
    if (accept || (state_d != StSend)) begin
      tout_d = '0;
    end
`endif
  end

  // Outputs
  always_comb begin
    req_ready = '0;
    if (state_q == StSend) begin
      req_ready[gidx_q] = req_valid[gidx_q] & ~tx_busy;
    end
  end

  assign accept  = |req_ready;
  assign grant   = grant_q;
  assign tx_data = tx_data_q;
  assign tx_stb  = tx_stb_q;
  assign active  = active_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic [1:0]  grant;
  logic [7:0]  tx_data;
  logic        tx_stb;
  logic        tx_busy;
  logic        active;

  int n_cmp  = 0;
  int n_fail = 0;

  uart_tx_arbiter #(
    .NUM_REQ        (2),
    .GUARD_CYCLES   (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .grant     (grant),
    .tx_data   (tx_data),
    .tx_stb    (tx_stb),
    .tx_busy   (tx_busy),
    .active    (active)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy rises the cycle after a strobe and holds for 10 cycles.
  int busy_cnt;
  bit busy_en = 1'b1;
  always @(posedge clk or posedge rst) begin
    if (rst) busy_cnt <= 0;
    else if (busy_en && tx_stb) busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  logic [7:0] log_data[$];
  int         log_cyc[$];
  int         proto_err = 0;
  logic       prev_stb = 1'b0;
  always @(negedge clk) begin
    if (tx_stb) begin
      log_data.push_back(tx_data);
      log_cyc.push_back(cyc_cnt);
      if (prev_stb || tx_busy) proto_err <= proto_err + 1;
    end
    prev_stb <= tx_stb;
  end

  task automatic wait_accept(input int lane, input string name);
    int n;
    logic [1:0] exp_g;
    n = 0;
    exp_g = 2'b01 << lane;
    #1;
    while (!req_ready[lane] && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    n_cmp++;
    if (!req_ready[lane]) begin
      n_fail++;
      $display("FAIL %s: req_ready[%0d] got 0 after %0d cycles, want 1", name, lane, n);
    end else begin
      n_cmp++;
      if (grant !== exp_g) begin
        n_fail++;
        $display("FAIL %s grant: got %b want %b", name, grant, exp_g);
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic send_byte(input int lane, input logic [7:0] d, input logic l, input string name);
    req_valid[lane]       = 1'b1;
    req_data[8*lane +: 8] = d;
    req_last[lane]        = l;
    wait_accept(lane, name);
  endtask

  task automatic send_pkt(input int lane, input logic [31:0] bytes, input int len,
                          input string name);
    for (int i = 0; i < len; i++) begin
      send_byte(lane, bytes[8*i +: 8], (i == len - 1), name);
    end
    req_valid[lane] = 1'b0;
    req_last[lane]  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (active !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (active !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle: active got %b want 0", name, active);
    end
  endtask

  task automatic do_reset();
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    rst       = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    log_data.delete();
    log_cyc.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({grant, active, tx_stb, tx_data, req_ready} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset: grant=%b active=%b stb=%b data=%h ready=%b want all 0",
               grant, active, tx_stb, tx_data, req_ready);
    end
  endtask

  task automatic test_single();
    logic [7:0] exp_d[3];
    exp_d = '{8'h41, 8'h42, 8'h43};
    log_data.delete();
    req_valid[0] = 1'b1;
    req_data[7:0] = 8'h41;
    req_last[0] = 1'b0;
    #1;
    n_cmp++;
    if (grant !== 2'b00 || req_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL single cyc0: grant=%b ready=%b want 00/00", grant, req_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (grant !== 2'b01 || active !== 1'b1 || req_ready !== 2'b01 || tx_stb !== 1'b0) begin
      n_fail++;
      $display("FAIL single cyc1: grant=%b active=%b ready=%b stb=%b want 01/1/01/0",
               grant, active, req_ready, tx_stb);
    end
    @(negedge clk);
    n_cmp++;
    if (tx_stb !== 1'b1 || tx_data !== 8'h41) begin
      n_fail++;
      $display("FAIL single cyc2: stb=%b data=%h want 1/41", tx_stb, tx_data);
    end
    send_byte(0, 8'h42, 1'b0, "single b1");
    send_byte(0, 8'h43, 1'b1, "single b2");
    req_valid[0] = 1'b0;
    req_last[0]  = 1'b0;
    wait_idle("single");
    n_cmp++;
    if (log_data.size() != 3) begin
      n_fail++;
      $display("FAIL single count: got %0d strobes want 3", log_data.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (log_data[i] !== exp_d[i]) begin
          n_fail++;
          $display("FAIL single byte%0d: got %h want %h", i, log_data[i], exp_d[i]);
        end
      end
    end
    n_cmp++;
    if (grant !== 2'b00) begin
      n_fail++;
      $display("FAIL single release: grant got %b want 00", grant);
    end
  endtask

  task automatic test_contention();
    logic [7:0] exp_d[8];
    exp_d = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hA2, 8'hA3, 8'hD0, 8'hC0};
    do_reset();
    fork
      begin
        send_pkt(0, 32'h0000A1A0, 2, "cont A");
        send_pkt(0, 32'h0000A3A2, 2, "cont A2");
      end
      send_pkt(1, 32'h0000B1B0, 2, "cont B");
    join
    wait_idle("cont r1");
    @(negedge clk);
    fork
      send_pkt(0, 32'h000000C0, 1, "cont C");
      send_pkt(1, 32'h000000D0, 1, "cont D");
    join
    wait_idle("cont r2");
    n_cmp++;
    if (log_data.size() != 8) begin
      n_fail++;
      $display("FAIL contention count: got %0d strobes want 8", log_data.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (log_data[i] !== exp_d[i]) begin
          n_fail++;
          $display("FAIL contention byte%0d: got %h want %h", i, log_data[i], exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_gap();
    logic [7:0] exp_d[3];
    int exp_n;
    log_data.delete();
    send_byte(1, 8'h51, 1'b0, "gap b0");
    req_valid[1] = 1'b0;
    req_valid[0] = 1'b1;
    req_data[7:0] = 8'h61;
    req_last[0] = 1'b1;
`ifdef UART_TX_ARB_TIMEOUT_EN
    begin
      int n;
      n = 0;
      while (grant !== 2'b01 && n < 60) begin
        @(negedge clk);
        n++;
      end
      n_cmp++;
      if (grant !== 2'b01) begin
        n_fail++;
        $display("FAIL gap timeout release: grant got %b want 01", grant);
      end
    end
    wait_accept(0, "gap r0");
    req_valid[0] = 1'b0;
    exp_d = '{8'h51, 8'h61, 8'h00};
    exp_n = 2;
`else
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n_cmp++;
      if (grant !== 2'b10 || req_ready[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL gap cyc%0d: grant=%b ready0=%b want 10/0", i, grant, req_ready[0]);
      end
    end
    send_byte(1, 8'h52, 1'b1, "gap b1");
    req_valid[1] = 1'b0;
    req_last[1]  = 1'b0;
    wait_accept(0, "gap r0");
    req_valid[0] = 1'b0;
    exp_d = '{8'h51, 8'h52, 8'h61};
    exp_n = 3;
`endif
    req_last[0] = 1'b0;
    wait_idle("gap");
    n_cmp++;
    if (log_data.size() != exp_n) begin
      n_fail++;
      $display("FAIL gap count: got %0d strobes want %0d", log_data.size(), exp_n);
    end else begin
      for (int i = 0; i < exp_n; i++) begin
        n_cmp++;
        if (log_data[i] !== exp_d[i]) begin
          n_fail++;
          $display("FAIL gap byte%0d: got %h want %h", i, log_data[i], exp_d[i]);
        end
      end
    end
  endtask

  task automatic test_no_busy();
    log_data.delete();
    log_cyc.delete();
    busy_en = 1'b0;
    send_pkt(0, 32'h00007271, 2, "nobusy");
    wait_idle("nobusy");
    busy_en = 1'b1;
    n_cmp++;
    if (log_data.size() != 2) begin
      n_fail++;
      $display("FAIL nobusy count: got %0d strobes want 2", log_data.size());
    end else begin
      n_cmp++;
      if (log_data[0] !== 8'h71 || log_data[1] !== 8'h72) begin
        n_fail++;
        $display("FAIL nobusy data: got %h %h want 71 72", log_data[0], log_data[1]);
      end
      n_cmp++;
      if (log_cyc[1] - log_cyc[0] != 6) begin
        n_fail++;
        $display("FAIL nobusy spacing: got %0d cycles want 6", log_cyc[1] - log_cyc[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    log_data.delete();
    send_byte(0, 8'h81, 1'b0, "rstmid b0");
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({grant, active, tx_stb, tx_data, req_ready} !== 13'd0) begin
      n_fail++;
      $display("FAIL rstmid async: grant=%b active=%b stb=%b data=%h ready=%b want all 0",
               grant, active, tx_stb, tx_data, req_ready);
    end
    req_valid = '0;
    req_last  = '0;
    @(negedge clk);
    rst = 1'b0;
    log_data.delete();
    req_valid = 2'b11;
    req_data  = 16'h9291;
    req_last  = 2'b11;
    @(negedge clk);
    n_cmp++;
    if (grant !== 2'b01) begin
      n_fail++;
      $display("FAIL rstmid ptr0: grant got %b want 01", grant);
    end
    wait_accept(0, "rstmid r0");
    req_valid[0] = 1'b0;
    wait_accept(1, "rstmid r1");
    req_valid[1] = 1'b0;
    req_last = '0;
    wait_idle("rstmid");
    n_cmp++;
    if (log_data.size() != 2) begin
      n_fail++;
      $display("FAIL rstmid count: got %0d strobes want 2", log_data.size());
    end else begin
      n_cmp++;
      if (log_data[0] !== 8'h91 || log_data[1] !== 8'h92) begin
        n_fail++;
        $display("FAIL rstmid data: got %h %h want 91 92", log_data[0], log_data[1]);
      end
    end
  endtask

  task automatic test_protocol();
    n_cmp++;
    if (proto_err != 0) begin
      n_fail++;
      $display("FAIL protocol: got %0d bad strobes want 0", proto_err);
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_contention();
    test_gap();
    test_no_busy();
    test_reset_mid();
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
